// File: rtl/char_ram_arbiter.sv
// ---------------------------------------------------------------------------
// char_ram_arbiter
//
// Shares the single-port 1024 x 8 character RAM (32 x 32 cells, synchronous
// read, one-cycle latency) between video scan-out and a host requester.
// Video gets one fixed fetch slot per 16-pixel character cell while
// display_on is high; every other cycle belongs to the host, which talks
// through a req/ack handshake.
//
// Optional feature: define CHARRAM_CLEAR_EN to add a clear engine that fills
// the whole RAM with CLEAR_CHAR after every reset (busy=1 while running).
//
// Parameters
//   VID_SLOT    hpos[3:0] value of the video fetch slot (0..14)
//   CLEAR_CHAR  fill value written by the clear engine
//
// Ports
//   clk         pixel clock, rising edge
//   reset       asynchronous reset, active low
//   hpos, vpos  beam position from hvsync_generator
//   display_on  visible-area flag from hvsync_generator
//   ram_addr    RAM address (combinational mux)
//   ram_din     RAM write data
//   ram_we      RAM write enable
//   ram_dout    RAM read data, valid the cycle after the address
//   vid_char    registered character code for the current video cell
//   host_req    host request, held with its qualifiers until host_ack
//   host_we     1 = write, 0 = read
//   host_addr   {row[4:0], col[4:0]}
//   host_wdata  host write data
//   host_ack    one-cycle completion pulse (registered)
//   host_rdata  read data, valid with host_ack, held until the next read
//   busy        clear engine active
// ---------------------------------------------------------------------------
module char_ram_arbiter #(
    parameter logic [3:0] VID_SLOT   = 4'd14,
    parameter logic [7:0] CLEAR_CHAR = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    input  logic       display_on,
    output logic [9:0] ram_addr,
    output logic [7:0] ram_din,
    output logic       ram_we,
    input  logic [7:0] ram_dout,
    output logic [7:0] vid_char,
    input  logic       host_req,
    input  logic       host_we,
    input  logic [9:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic       host_ack,
    output logic [7:0] host_rdata,
    output logic       busy
);

`ifdef CHARRAM_CLEAR_EN
    typedef enum logic [1:0] {IDLE, RDWAIT, ACK, CLEAR} state_t;
    logic [9:0] clr_addr;
`else
    typedef enum logic [1:0] {IDLE, RDWAIT, ACK} state_t;
`endif

    state_t     state;
    logic       video_slot;
    logic       vid_pending;
    logic       issue;
    logic [4:0] next_col;

    assign video_slot = display_on && (hpos[3:0] == VID_SLOT);
    // Fetch the next cell's code so it is ready when the beam reaches it;
    // the 5-bit add wraps column 31 back to column 0 on the same row.
    assign next_col   = hpos[8:4] + 5'd1;
    assign issue      = (state == IDLE) && !video_slot && host_req;

    // Address/data mux: video always wins its slot, then clear, then host.
    always_comb begin
        ram_addr = host_addr;
        ram_din  = host_wdata;
        ram_we   = 1'b0;
        if (video_slot) begin
            ram_addr = {vpos[8:4], next_col};
        end
`ifdef CHARRAM_CLEAR_EN
        else if (state == CLEAR) begin
            ram_addr = clr_addr;
            ram_din  = CLEAR_CHAR;
            ram_we   = 1'b1;
        end
`endif
        else if (issue) begin
            ram_we = host_we;
        end
    end

    // Video capture: RAM data arrives the cycle after the fetch slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vid_pending <= 1'b0;
            vid_char    <= 8'h00;
        end else begin
            vid_pending <= video_slot;
            if (vid_pending)
                vid_char <= ram_dout;
        end
    end

    // Host FSM; host_ack is set on entry to ACK so it is high for that cycle only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            host_ack   <= 1'b0;
            host_rdata <= 8'h00;
`ifdef CHARRAM_CLEAR_EN
            state      <= CLEAR;
            clr_addr   <= 10'd0;
            busy       <= 1'b1;
`else
            state      <= IDLE;
`endif
        end else begin
            host_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (issue) begin
                        if (host_we) begin
                            state    <= ACK;
                            host_ack <= 1'b1;
                        end else begin
                            state <= RDWAIT;
                        end
                    end
                end
                RDWAIT: begin
                    host_rdata <= ram_dout;
                    host_ack   <= 1'b1;
                    state      <= ACK;
                end
                ACK: begin
                    state <= IDLE;
                end
`ifdef CHARRAM_CLEAR_EN
                CLEAR: begin
                    if (!video_slot) begin
                        clr_addr <= clr_addr + 10'd1;
                        if (clr_addr == 10'h3FF) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef CHARRAM_CLEAR_EN
    logic unused_bits;
    assign unused_bits = ^{hpos[9], vpos[9], vpos[3:0]};
`else
    logic unused_bits;
    assign busy        = 1'b0;
    assign unused_bits = ^{hpos[9], vpos[9], vpos[3:0], CLEAR_CHAR};
`endif

endmodule
